// File: rtl/prbs_checker.sv
// prbs_checker: receive-side parallel PRBS checker.
// Seeds its LFSR from the received word stream, verifies the prediction for
// LockWords consecutive words, then free-runs and counts bit errors against
// the predicted stream. Lock is dropped when one WinWords-long window collects
// LossThresh or more bit errors.
// Optional first-error capture ports exist only when PRBS_CHK_FIRST_ERR_EN is
// defined.
//
// Stream convention: bit 0 of a word is the earliest bit in time. The LFSR
// state holds the last Length stream bits, with s_q[0] the oldest and
// s_q[Length-1] the newest, so a received word shifts in at the top.

module prbs_checker #(
   parameter int Length     = 31,
   parameter int Bits       = 16,
   parameter int LockWords  = 8,
   parameter int WinWords   = 256,
   parameter int LossThresh = 32,
   parameter int CntWidth   = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                enable,
   input  logic                in_valid,
   input  logic [Bits-1:0]     in_data,
   input  logic                in_inv,
   output logic                locked,
   output logic                err_word,
   output logic [CntWidth-1:0] err_cnt,
   output logic [CntWidth-1:0] word_cnt,
   output logic                err_sat,
   output logic                seed_good
`ifdef PRBS_CHK_FIRST_ERR_EN
   ,
   output logic                first_err_valid,
   output logic [CntWidth-1:0] first_err_word,
   output logic [Bits-1:0]     first_err_mask
`endif
);

   // Feedback lag of the standard ITU PRBS polynomials x^Length + x^lag + 1.
   function automatic int prbs_tap_lag(input int len);
      case (len)
         7:       return 6;
         9:       return 5;
         15:      return 14;
         23:      return 18;
         31:      return 28;
         default: return 0;
      endcase
   endfunction

   localparam int TapLag     = prbs_tap_lag(Length);
   localparam int TapIdx     = Length - TapLag;
   localparam int SeedWords  = (Length + Bits - 1) / Bits;
   localparam int SeedCntW   = (SeedWords > 1) ? $clog2(SeedWords) : 1;
   localparam int GoodCntW   = (LockWords > 1) ? $clog2(LockWords) : 1;
   localparam int WinCntW    = (WinWords > 1) ? $clog2(WinWords) : 1;
   localparam int WinSumMax  = (WinWords * Bits > LossThresh) ? WinWords * Bits : LossThresh;
   localparam int WinSumW    = $clog2(WinSumMax + 1);
   localparam int PopW       = $clog2(Bits + 1);
   localparam int CntW1      = CntWidth + 1;

   localparam logic [SeedCntW-1:0] SeedLast  = SeedCntW'(SeedWords - 1);
   localparam logic [GoodCntW-1:0] GoodLast  = GoodCntW'(LockWords - 1);
   localparam logic [WinCntW-1:0]  WinLast   = WinCntW'(WinWords - 1);
   localparam logic [WinSumW-1:0]  LossLimit = WinSumW'(LossThresh);

   // Parameter consistency: a word must not cover the whole LFSR, and the
   // polynomial must be one we know.
   if (Bits >= Length) begin : g_bad_bits
      $fatal(1, "prbs_checker: Bits (%0d) must be less than Length (%0d)", Bits, Length);
   end
   if (TapLag == 0) begin : g_bad_length
      $fatal(1, "prbs_checker: unsupported PRBS Length %0d", Length);
   end

   // Parallel advance by Bits stream bits: Bits serial steps unrolled into
   // XOR logic, equivalent to multiplying by the generator's next-state matrix.
   function automatic logic [Length-1:0] prbs_advance(input logic [Length-1:0] s);
      logic [Length-1:0] t;
      logic              nb;
      t = s;
      for (int i = 0; i < Bits; i++) begin
         nb = t[0] ^ t[TapIdx];
         t  = {nb, t[Length-1:1]};
      end
      return t;
   endfunction

   function automatic logic [PopW-1:0] popcount(input logic [Bits-1:0] v);
      logic [PopW-1:0] c;
      c = '0;
      for (int i = 0; i < Bits; i++) begin
         c = c + PopW'(v[i]);
      end
      return c;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEED,
      ST_VERIFY,
      ST_LOCKED
   } state_t;

   state_t                state_q,    state_d;
   logic [Length-1:0]     s_q,        s_d;
   logic [SeedCntW-1:0]   seed_cnt_q, seed_cnt_d;
   logic [GoodCntW-1:0]   good_cnt_q, good_cnt_d;
   logic [WinCntW-1:0]    win_cnt_q,  win_cnt_d;
   logic [WinSumW-1:0]    win_sum_q,  win_sum_d;
   logic                  err_word_q, err_word_d;
   logic [CntWidth-1:0]   err_cnt_q,  err_cnt_d;
   logic [CntWidth-1:0]   word_cnt_q, word_cnt_d;
   logic                  err_sat_q,  err_sat_d;

   logic [Bits-1:0]       d;
   logic [Length-1:0]     sn;
   logic [Bits-1:0]       exp_w;
   logic [Bits-1:0]       diff;
   logic [PopW-1:0]       e;
   logic                  mism;
   logic [CntWidth:0]     err_sum;
   logic [WinSumW-1:0]    win_sum_nxt;

   // Datapath: normalise the received word and compare it with the prediction.
   always_comb begin
      d     = in_data ^ {Bits{in_inv}};
      sn    = prbs_advance(s_q);
      exp_w = sn[Length-1:Length-Bits];
      diff  = d ^ exp_w;
      e     = popcount(diff);
      mism  = |diff;
   end

   // Next-state logic for the lock FSM, LFSR, window monitor and counters.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_d     = state_q;
      s_d         = s_q;
      seed_cnt_d  = seed_cnt_q;
      good_cnt_d  = good_cnt_q;
      win_cnt_d   = win_cnt_q;
      win_sum_d   = win_sum_q;
      err_word_d  = err_word_q;
      err_cnt_d   = err_cnt_q;
      word_cnt_d  = word_cnt_q;
      err_sat_d   = err_sat_q;
      err_sum     = {1'b0, err_cnt_q} + CntW1'(e);
      win_sum_nxt = win_sum_q + WinSumW'(e);

      if (!enable) begin
         state_d    = ST_IDLE;
         err_word_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d    = ST_SEED;
               seed_cnt_d = '0;
               err_word_d = 1'b0;
            end

            ST_SEED: begin
               err_word_d = 1'b0;
               if (in_valid) begin
                  s_d = {d, s_q[Length-1:Bits]};
                  if (seed_cnt_q == SeedLast) begin
                     state_d    = ST_VERIFY;
                     good_cnt_d = '0;
                  end else begin
                     seed_cnt_d = seed_cnt_q + 1'b1;
                  end
               end
            end

            ST_VERIFY: begin
               if (in_valid) begin
                  s_d        = sn;
                  err_word_d = mism;
                  if (mism) begin
                     state_d    = ST_SEED;
                     seed_cnt_d = '0;
                  end else if (good_cnt_q == GoodLast) begin
                     // A zero seed predicts zeros forever and would accept a
                     // dead link, so lock also needs a non-zero LFSR.
                     if (seed_good) begin
                        state_d   = ST_LOCKED;
                        win_cnt_d = '0;
                        win_sum_d = '0;
                     end else begin
                        state_d    = ST_SEED;
                        seed_cnt_d = '0;
                     end
                  end else begin
                     good_cnt_d = good_cnt_q + 1'b1;
                  end
               end
            end

            ST_LOCKED: begin
               if (in_valid) begin
                  s_d        = sn;
                  err_word_d = mism;
                  if (err_sum[CntWidth] || (&err_sum[CntWidth-1:0])) begin
                     err_cnt_d = '1;
                     err_sat_d = 1'b1;
                  end else begin
                     err_cnt_d = err_sum[CntWidth-1:0];
                  end
                  if (word_cnt_q != '1) begin
                     word_cnt_d = word_cnt_q + 1'b1;
                  end
                  if (win_cnt_q == WinLast) begin
                     win_cnt_d = '0;
                     win_sum_d = '0;
                     if (win_sum_nxt >= LossLimit) begin
                        state_d    = ST_SEED;
                        seed_cnt_d = '0;
                     end
                  end else begin
                     win_cnt_d = win_cnt_q + 1'b1;
                     win_sum_d = win_sum_nxt;
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Clear takes priority over any error accumulated on the same word.
      if (clear) begin
         err_cnt_d  = '0;
         word_cnt_d = '0;
         err_sat_d  = 1'b0;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         s_q        <= '0;
         seed_cnt_q <= '0;
         good_cnt_q <= '0;
         win_cnt_q  <= '0;
         win_sum_q  <= '0;
         err_word_q <= 1'b0;
         err_cnt_q  <= '0;
         word_cnt_q <= '0;
         err_sat_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         s_q        <= s_d;
         seed_cnt_q <= seed_cnt_d;
         good_cnt_q <= good_cnt_d;
         win_cnt_q  <= win_cnt_d;
         win_sum_q  <= win_sum_d;
         err_word_q <= err_word_d;
         err_cnt_q  <= err_cnt_d;
         word_cnt_q <= word_cnt_d;
         err_sat_q  <= err_sat_d;
      end
   end

   assign locked    = (state_q == ST_LOCKED);
   assign err_word  = err_word_q;
   assign err_cnt   = err_cnt_q;
   assign word_cnt  = word_cnt_q;
   assign err_sat   = err_sat_q;
   assign seed_good = |s_q;

`ifdef PRBS_CHK_FIRST_ERR_EN
   logic                fe_valid_q, fe_valid_d;
   logic [CntWidth-1:0] fe_word_q,  fe_word_d;
   logic [Bits-1:0]     fe_mask_q,  fe_mask_d;

   // Capture the first erroneous locked word since reset or clear.
   always_comb begin
      fe_valid_d = fe_valid_q;
      fe_word_d  = fe_word_q;
      fe_mask_d  = fe_mask_q;
      if (enable && in_valid && (state_q == ST_LOCKED) && mism && !fe_valid_q) begin
         fe_valid_d = 1'b1;
         fe_word_d  = word_cnt_q;
         fe_mask_d  = diff;
      end
      if (clear) begin
         fe_valid_d = 1'b0;
         fe_word_d  = '0;
         fe_mask_d  = '0;
      end
   end

   // First-error capture registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fe_valid_q <= 1'b0;
         fe_word_q  <= '0;
         fe_mask_q  <= '0;
      end else begin
         fe_valid_q <= fe_valid_d;
         fe_word_q  <= fe_word_d;
         fe_mask_q  <= fe_mask_d;
      end
   end

   assign first_err_valid = fe_valid_q;
   assign first_err_word  = fe_word_q;
   assign first_err_mask  = fe_mask_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench for prbs_checker (Length=31, Bits=16).
// The stimulus process drives one cycle at a time and pushes the hand-derived
// expected outputs for that cycle; a monitor pops one entry after each clock
// edge and compares. The PRBS31 source is a serial Fibonacci LFSR
// (x^31 + x^28 + 1) seeded with 31'h1.

module tb_prbs_checker;

   localparam int B  = 16;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic          enable;
   logic          in_valid;
   logic [B-1:0]  in_data;
   logic          in_inv;
   logic          locked;
   logic          err_word;
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] word_cnt;
   logic          err_sat;
   logic          seed_good;
`ifdef PRBS_CHK_FIRST_ERR_EN
   logic          first_err_valid;
   logic [CW-1:0] first_err_word;
   logic [B-1:0]  first_err_mask;
`endif

   prbs_checker #(
      .Length     (31),
      .Bits       (B),
      .LockWords  (8),
      .WinWords   (256),
      .LossThresh (32),
      .CntWidth   (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .enable    (enable),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_inv    (in_inv),
      .locked    (locked),
      .err_word  (err_word),
      .err_cnt   (err_cnt),
      .word_cnt  (word_cnt),
      .err_sat   (err_sat),
      .seed_good (seed_good)
`ifdef PRBS_CHK_FIRST_ERR_EN
      ,
      .first_err_valid (first_err_valid),
      .first_err_word  (first_err_word),
      .first_err_mask  (first_err_mask)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      logic        locked;
      logic        err_word;
      logic [31:0] err_cnt;
      logic [31:0] word_cnt;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // Expected outputs after the cycle currently being driven.
   logic        e_locked;
   logic        e_err_word;
   logic [31:0] e_err_cnt;
   logic [31:0] e_word_cnt;

   // Serial PRBS31 source; g[0] is the newest bit.
   logic [30:0] g;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic gen_word(output logic [B-1:0] w);
      for (int i = 0; i < B; i++) begin
         logic nb;
         nb   = g[30] ^ g[27];
         g    = {g[29:0], nb};
         w[i] = nb;
      end
   endtask

   task automatic drive(input logic v, input logic [B-1:0] data, input logic inv,
                        input logic clr, input int tag);
      exp_t r;
      @(negedge clk);
      in_valid = v;
      in_data  = data;
      in_inv   = inv;
      clear    = clr;
      r.tag      = tag;
      r.locked   = e_locked;
      r.err_word = e_err_word;
      r.err_cnt  = e_err_cnt;
      r.word_cnt = e_word_cnt;
      exp_q.push_back(r);
   endtask

   task automatic drain(input string name);
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
      @(posedge clk);
      #2;
      check({name, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_locked"},    locked,    0);
      check({name, "_err_word"},  err_word,  0);
      check({name, "_err_cnt"},   err_cnt,   0);
      check({name, "_word_cnt"},  word_cnt,  0);
      check({name, "_err_sat"},   err_sat,   0);
      check({name, "_seed_good"}, seed_good, 0);
   endtask

   task automatic pulse_reset(input string name);
      @(negedge clk);
      reset    = 1'b1;
      enable   = 1'b0;
      in_valid = 1'b0;
      clear    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check_zero_outputs(name);
      e_locked   = 1'b0;
      e_err_word = 1'b0;
      e_err_cnt  = '0;
      e_word_cnt = '0;
   endtask

   // Monitor: one expected entry per driven cycle, compared after the edge.
   initial begin
      exp_t r;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            check($sformatf("locked@%0d", r.tag),   locked,   r.locked);
            check($sformatf("err_word@%0d", r.tag), err_word, r.err_word);
            check($sformatf("err_cnt@%0d", r.tag),  err_cnt,  r.err_cnt);
            check($sformatf("word_cnt@%0d", r.tag), word_cnt, r.word_cnt);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [B-1:0] w;
      int           lw;

      reset      = 1'b1;
      clear      = 1'b0;
      enable     = 1'b0;
      in_valid   = 1'b0;
      in_inv     = 1'b0;
      in_data    = '0;
      e_locked   = 1'b0;
      e_err_word = 1'b0;
      e_err_cnt  = '0;
      e_word_cnt = '0;
      g          = 31'h1;

      repeat (3) @(negedge clk);
      check_zero_outputs("in_reset");
      reset = 1'b0;
      @(negedge clk);
      check_zero_outputs("after_reset");

      // Clean stream: 2 seed words, 8 verify words, lock after word 9.
      enable = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0, -1);
      for (int k = 0; k < 1010; k++) begin
         gen_word(w);
         e_locked   = (k >= 9);
         e_word_cnt = (k >= 10) ? k - 9 : 0;
         drive(1'b1, w, 1'b0, 1'b0, k);
      end
      lw = 1000;

      // Single-bit error on bit 5.
      gen_word(w);
      e_err_word = 1'b1;
      e_err_cnt  = 1;
      e_word_cnt = e_word_cnt + 1;
      drive(1'b1, w ^ 16'h0020, 1'b0, 1'b0, 2000);
      lw++;
      e_err_word = 1'b0;
      while (lw % 256 != 0) begin
         gen_word(w);
         e_word_cnt = e_word_cnt + 1;
         drive(1'b1, w, 1'b0, 1'b0, 2000 + lw);
         lw++;
      end

      // Three fully inverted words at the start of a window: 48 bit errors.
      for (int i = 0; i < 3; i++) begin
         gen_word(w);
         e_err_word = 1'b1;
         e_err_cnt  = e_err_cnt + 16;
         e_word_cnt = e_word_cnt + 1;
         drive(1'b1, w ^ 16'hFFFF, 1'b0, 1'b0, 3000 + i);
         lw++;
      end
      e_err_word = 1'b0;
      while (lw % 256 != 0) begin
         gen_word(w);
         e_word_cnt = e_word_cnt + 1;
         e_locked   = (lw % 256 != 255);
         drive(1'b1, w, 1'b0, 1'b0, 3000 + lw);
         lw++;
      end

      // Relock on 10 clean words; counters held meanwhile.
      for (int i = 0; i < 10; i++) begin
         gen_word(w);
         e_locked = (i == 9);
         drive(1'b1, w, 1'b0, 1'b0, 5000 + i);
      end
      for (int i = 0; i < 2; i++) begin
         gen_word(w);
         e_word_cnt = e_word_cnt + 1;
         drive(1'b1, w, 1'b0, 1'b0, 5100 + i);
      end
      drain("clean");
      check("seed_good_locked", seed_good, 1);

      // Inverted data with gaps; garbage on idle cycles must be ignored.
      pulse_reset("rst_inv");
      enable = 1'b1;
      drive(1'b0, '0, 1'b1, 1'b0, 6000);
      for (int n = 0; n < 30; n++) begin
         gen_word(w);
         e_locked   = (n >= 9);
         e_word_cnt = (n >= 10) ? n - 9 : 0;
         drive(1'b1, ~w, 1'b1, 1'b0, 6100 + n);
         drive(1'b0, B'($urandom), 1'b1, 1'b0, 6200 + n);
      end
      drain("inv");

      // All-zero stream never locks.
      pulse_reset("rst_zero");
      enable = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0, 7000);
      for (int n = 0; n < 40; n++) begin
         drive(1'b1, '0, 1'b0, 1'b0, 7100 + n);
      end
      drain("zero");
      check("zero_seed_good", seed_good, 0);
      check("zero_locked", locked, 0);

      // Clear coincident with an error word, then async reset while locked.
      pulse_reset("rst_clr");
      enable = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0, 8000);
      for (int i = 0; i < 10; i++) begin
         gen_word(w);
         e_locked = (i == 9);
         drive(1'b1, w, 1'b0, 1'b0, 8100 + i);
      end
      gen_word(w);
      e_err_word = 1'b1;
      e_err_cnt  = 5;
      e_word_cnt = 1;
      drive(1'b1, w ^ 16'h001F, 1'b0, 1'b0, 8200);
      gen_word(w);
      e_err_cnt  = 0;
      e_word_cnt = 0;
      drive(1'b1, w ^ 16'h0001, 1'b0, 1'b1, 8201);
`ifdef PRBS_CHK_FIRST_ERR_EN
      @(posedge clk);
      #1;
      check("fe_valid_after_clear", first_err_valid, 0);
`endif
      gen_word(w);
      e_err_cnt  = 5;
      e_word_cnt = 1;
      drive(1'b1, w ^ 16'h001F, 1'b0, 1'b0, 8202);
      gen_word(w);
      e_err_word = 1'b0;
      e_word_cnt = 2;
      drive(1'b1, w, 1'b0, 1'b0, 8203);
      drain("clr");
`ifdef PRBS_CHK_FIRST_ERR_EN
      check("fe_valid", first_err_valid, 1);
      check("fe_word", first_err_word, 0);
      check("fe_mask", first_err_mask, 16'h001F);
`endif
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_zero_outputs("async_reset");
      @(negedge clk);
      enable = 1'b0;
      reset  = 1'b0;
      @(negedge clk);
      check_zero_outputs("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
